// File: rtl/reg_32b.sv
`default_nettype none
// ============================================================================
// Module   : reg_32b
// Purpose  : Parallel-load word register built from one D flip-flop per bit.
//            On every rising clk edge each bit captures data_in, or loads
//            RESET_VALUE when res is sampled high. There is no enable, so the
//            register reloads every cycle while res is low.
// Ports    : data_out [0:WIDTH-1] out  registered word, bit 0 is the MSB
//            data_in  [0:WIDTH-1] in   word captured at each rising edge
//            clk                  in   clock, rising edge active
//            res                  in   synchronous active-high clear
// Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Single-bit D flip-flop with synchronous clear. When the clear is sampled
// high the flop loads i_clr_val instead of i_d.
// ----------------------------------------------------------------------------
module reg_32b_dff (
    output logic o_q,
    input  logic i_d,
    input  logic clk,
    input  logic i_clr,
    input  logic i_clr_val
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= i_clr_val;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// ----------------------------------------------------------------------------
// Word register: WIDTH independent bit cells sharing clk and res. Bit i of
// data_out is driven only by the cell fed from bit i of data_in, so there is
// no reordering and no combinational path from data_in to data_out.
// ----------------------------------------------------------------------------
module reg_32b #(
    parameter int                 WIDTH       = 32,
    parameter logic [0:WIDTH-1]   RESET_VALUE = '0
) (
    output logic [0:WIDTH-1] data_out,
    input  logic [0:WIDTH-1] data_in,
    input  logic             clk,
    input  logic             res
);

    logic [0:WIDTH-1] w_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        reg_32b_dff u_dff (
            .o_q       (w_q[gi]),
            .i_d       (data_in[gi]),
            .clk       (clk),
            .i_clr     (res),
            .i_clr_val (RESET_VALUE[gi])
        );
    end

    assign data_out = w_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_32b.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_32b
// Purpose  : Self-checking bench for reg_32b. A reference model records the
//            word the register should hold after every rising edge into a
//            queue; a separate monitor pops that word and compares it with
//            data_out shortly after the edge and again twice mid-cycle to
//            confirm the output is stable between edges.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps

module tb_reg_32b;

    localparam int c_width = 32;

    logic [0:c_width-1] data_out;
    logic [0:c_width-1] data_in;
    logic               clk;
    logic               res;

    int checks   = 0;
    int failures = 0;

    logic [0:c_width-1] exp_q[$];
    logic [0:c_width-1] last_exp;

    reg_32b #(
        .WIDTH       (c_width),
        .RESET_VALUE ('0)
    ) dut (
        .data_out (data_out),
        .data_in  (data_in),
        .clk      (clk),
        .res      (res)
    );

    // 10 ns period, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [0:c_width-1] act,
                         input logic [0:c_width-1] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: data_out=%h expected=%h", name, $time, act, req);
        end
    endtask

    // Reference model: after an edge the register holds zero if reset was
    // sampled, otherwise exactly the word presented at that edge.
    always @(posedge clk) begin
        exp_q.push_back(res ? 32'h0000_0000 : data_in);
    end

    // Monitor: compare just after the edge, then twice more before the next.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at %0t: data_out=%h expected=<queued word>", $time, data_out);
        end else begin
            last_exp = exp_q.pop_front();
            check("load", data_out, last_exp);
        end
        #4;
        check("hold_mid", data_out, last_exp);
        #4;
        check("hold_late", data_out, last_exp);
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, data_out=%h expected=<finish>", data_out);
        $fatal(1, "timeout");
    end

    task automatic next_edge_plus(input int d);
        @(posedge clk);
        #(d);
    endtask

    initial begin
        int d;
        // Reset hold with data_in counting every 6 ns.
        res     = 1'b1;
        data_in = 32'd0;
        #6 data_in = 32'd1;   // 6
        #6 data_in = 32'd2;   // 12
        #6 data_in = 32'd3;   // 18
        #6 data_in = 32'd4;   // 24
        #6 data_in = 32'd5;   // 30
        #4 res     = 1'b0;    // 34
        #2 data_in = 32'd6;   // 36
        #6 data_in = 32'd7;   // 42
        #6 data_in = 32'd8;   // 48
        #6 data_in = 32'd9;   // 54

        // Inter-edge stability: wiggle data_in at +1, +3, +7 ns.
        @(posedge clk);       // 55 loads 9
        #1 data_in = 32'hDEAD_BEEF;
        #2 data_in = 32'h0BAD_F00D;
        #4 data_in = 32'h1234_5678;

        // Reset priority in mid-operation.
        next_edge_plus(1);    // edge loaded 0x12345678
        res     = 1'b1;
        data_in = 32'hFFFF_FFFF;
        next_edge_plus(1);    // edge cleared to zero
        res     = 1'b0;
        next_edge_plus(2);    // edge loads 0xFFFFFFFF
        // Short reset pulse not spanning an edge.
        res = 1'b1;
        #2 res = 1'b0;

        // Bit independence / ordering patterns, one per edge.
        next_edge_plus(1); data_in = 32'h8000_0000;
        next_edge_plus(1); data_in = 32'h0000_0001;
        next_edge_plus(1); data_in = 32'hAAAA_AAAA;
        next_edge_plus(1); data_in = 32'h5555_5555;
        next_edge_plus(1);
        checks++;
        if (data_out[0] !== 1'b0 || data_out[31] !== 1'b1) begin
            failures++;
            $display("FAIL bit_order at %0t: data_out[0]=%b data_out[31]=%b expected 0 and 1 (0x55555555)",
                     $time, data_out[0], data_out[31]);
        end
        data_in = 32'h8000_0000;
        next_edge_plus(2);
        checks++;
        if (data_out[0] !== 1'b1 || data_out[1:31] !== 31'd0) begin
            failures++;
            $display("FAIL msb_bit0 at %0t: data_out=%h expected=80000000 with bit 0 set", $time, data_out);
        end

        // Randomized traffic, including occasional resets and short pulses.
        for (int i = 0; i < 200; i++) begin
            d = $urandom_range(1, 7);
            next_edge_plus(d);
            data_in = $urandom;
            res     = ($urandom_range(0, 7) == 0);
            if (!res && $urandom_range(0, 9) == 0) begin
                res = 1'b1;
                #1 res = 1'b0;
            end
        end

        @(posedge clk);
        res = 1'b0;
        @(posedge clk);
        #9.5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
